// File: rtl/kmc_sppkg.sv
// Shared definitions for the KMC scratch-pad RAM: clear-FSM states, default
// geometry (also used by the CRAM decode) and the word parity helper.
package kmc_sppkg;

  localparam int SP_DWIDTH = 8;
  localparam int SP_AWIDTH = 4;

  typedef enum logic {
    SP_CLEAR = 1'b0,
    SP_READY = 1'b1
  } sp_state_e;

  // Even parity; callers zero-extend, which leaves the parity unchanged.
  function automatic logic sp_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/kmc_spram_clr.sv
// Clear engine: sweeps every word once after reset or on spCLR, restarting
// from word 0 whenever spCLR arrives mid-sweep.
module kmc_spram_clr
  import kmc_sppkg::*;
#(
  parameter int AWIDTH = SP_AWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  output logic              busy_o,
  output logic [AWIDTH-1:0] addr_o,
  output logic              we_o
);

  localparam logic [AWIDTH-1:0] LAST = '1;

  sp_state_e         state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SP_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Terminal detect by compare so the counter never wraps into a second pass.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SP_CLEAR: begin
        if (clr_i) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = SP_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SP_READY: begin
        if (clr_i) begin
          state_d = SP_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SP_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q == SP_CLEAR);
  assign we_o   = busy_o;
  assign addr_o = cnt_q;

endmodule

// File: rtl/kmc_spram.sv
// Parametrised KMC scratch-pad RAM: one write port, two registered-address
// read ports, sequential clear engine. Optional parity: KMCSP_PARITY_EN.
module kmc_spram
  import kmc_sppkg::*;
#(
  parameter int                DWIDTH = SP_DWIDTH,
  parameter int                AWIDTH = SP_AWIDTH,
  parameter logic [DWIDTH-1:0] CLRVAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spCLKEN,
  input  logic              spWR,
  input  logic [AWIDTH-1:0] spWADDR,
  input  logic [DWIDTH-1:0] spDIN,
  input  logic              spRAZERO,
  input  logic [AWIDTH-1:0] spRADDRA,
  input  logic [AWIDTH-1:0] spRADDRB,
  input  logic              spCLR,
  output logic [DWIDTH-1:0] spDOUTA,
  output logic [DWIDTH-1:0] spDOUTB,
  output logic              spBUSY,
  output logic              spPERR
);

  localparam int DEPTH = 2**AWIDTH;
`ifdef KMCSP_PARITY_EN
  localparam int MW = DWIDTH + 1;
`else
  localparam int MW = DWIDTH;
`endif

  logic              busy, clr_we;
  logic [AWIDTH-1:0] clr_addr;

  kmc_spram_clr #(.AWIDTH(AWIDTH)) u_clr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (spCLR),
    .busy_o (busy),
    .addr_o (clr_addr),
    .we_o   (clr_we)
  );

  logic [MW-1:0]     mem [DEPTH];
  logic              we;
  logic [AWIDTH-1:0] waddr;
  logic [DWIDTH-1:0] wdat;
  logic [MW-1:0]     wword;

  // Core writes only land in READY; the sweep owns the port while clearing.
  assign we    = clr_we | (spWR & spCLKEN);
  assign waddr = clr_we ? clr_addr : spWADDR;
  assign wdat  = clr_we ? CLRVAL : spDIN;
`ifdef KMCSP_PARITY_EN
  assign wword = {sp_parity(64'(wdat)), wdat};
`else
  assign wword = wdat;
`endif

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wword;
  end

  logic [AWIDTH-1:0] raddra_q, raddrb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddra_q <= '0;
      raddrb_q <= '0;
    end else begin
      raddra_q <= spRAZERO ? '0 : spRADDRA;
      raddrb_q <= spRADDRB;
    end
  end

  logic [MW-1:0] rda, rdb;
  assign rda = mem[raddra_q];
  assign rdb = mem[raddrb_q];

  assign spDOUTA = busy ? CLRVAL : rda[DWIDTH-1:0];
  assign spDOUTB = busy ? CLRVAL : rdb[DWIDTH-1:0];
  assign spBUSY  = busy;

`ifdef KMCSP_PARITY_EN
  logic perr_q, perr_d;

  assign perr_d = (rda[DWIDTH] != sp_parity(64'(rda[DWIDTH-1:0]))) |
                  (rdb[DWIDTH] != sp_parity(64'(rdb[DWIDTH-1:0])));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       perr_q <= 1'b0;
    else if (busy) perr_q <= 1'b0;
    else           perr_q <= perr_d;
  end

  assign spPERR = perr_q;
`else
  assign spPERR = 1'b0;
`endif

endmodule

// File: tb/tb_kmc_spram.sv
// Directed bench for kmc_spram (8x16 defaults): vector table for READY-state
// reads/writes plus hand sequences for reset sweep, clear restart and parity.
module tb_kmc_spram;

  logic       clk = 1'b0;
  logic       rst;
  logic       spCLKEN, spWR, spRAZERO, spCLR;
  logic [3:0] spWADDR, spRADDRA, spRADDRB;
  logic [7:0] spDIN, spDOUTA, spDOUTB;
  logic       spBUSY, spPERR;

  int nchk = 0;
  int nerr = 0;

  kmc_spram #(.DWIDTH(8), .AWIDTH(4), .CLRVAL(8'h00)) dut (
    .clk      (clk),
    .rst      (rst),
    .spCLKEN  (spCLKEN),
    .spWR     (spWR),
    .spWADDR  (spWADDR),
    .spDIN    (spDIN),
    .spRAZERO (spRAZERO),
    .spRADDRA (spRADDRA),
    .spRADDRB (spRADDRB),
    .spCLR    (spCLR),
    .spDOUTA  (spDOUTA),
    .spDOUTB  (spDOUTB),
    .spBUSY   (spBUSY),
    .spPERR   (spPERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       clken;
    logic [3:0] waddr;
    logic [7:0] din;
    logic       razero;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] expa;
    logic [7:0] expb;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    spWR = 0; spCLKEN = 0; spCLR = 0; spRAZERO = 0;
  endtask

  task automatic wr_word(input logic [3:0] a, input logic [7:0] d);
    spWR = 1; spCLKEN = 1; spWADDR = a; spDIN = d;
    step();
    spWR = 0; spCLKEN = 0;
  endtask

  int cyc;
  int bad;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 4'd3,  8'hA5, 1'b0, 4'd3,  4'd0,  8'hA5, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 4'd3,  8'hFF, 1'b0, 4'd3,  4'd3,  8'hA5, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 4'd0,  8'h11, 1'b0, 4'd0,  4'd3,  8'h11, 8'hA5};
    vecs[3] = '{1'b1, 1'b1, 4'd7,  8'h77, 1'b0, 4'd7,  4'd0,  8'h77, 8'h11};
    vecs[4] = '{1'b0, 1'b1, 4'd7,  8'h00, 1'b1, 4'd7,  4'd7,  8'h11, 8'h77};
    vecs[5] = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 4'd7,  4'd7,  8'h77, 8'h77};
    vecs[6] = '{1'b1, 1'b1, 4'd15, 8'h5A, 1'b0, 4'd15, 4'd14, 8'h5A, 8'h00};
    vecs[7] = '{1'b0, 1'b1, 4'd14, 8'h99, 1'b0, 4'd14, 4'd15, 8'h00, 8'h5A};

    rst = 1; idle(); spWADDR = 0; spDIN = 0; spRADDRA = 0; spRADDRB = 0;
    step(); step();
    chk("reset_busy", 32'(spBUSY), 1);
    chk("reset_douta", 32'(spDOUTA), 0);
    chk("reset_doutb", 32'(spDOUTB), 0);
    chk("reset_perr", 32'(spPERR), 0);

    // Power-up sweep: exactly 16 edges after release.
    rst = 0;
    cyc = 0;
    while (spBUSY && cyc < 40) begin step(); cyc++; end
    chk("initial_sweep_len", 32'(cyc), 16);

    bad = 0;
    for (int a = 0; a < 16; a++) begin
      spRADDRA = 4'(a); spRADDRB = 4'(15 - a);
      step();
      if (spDOUTA !== 8'h00 || spDOUTB !== 8'h00) bad++;
    end
    chk("all_words_clear", 32'(bad), 0);

    for (int i = 0; i < 8; i++) begin
      spWR = vecs[i].wr; spCLKEN = vecs[i].clken; spWADDR = vecs[i].waddr;
      spDIN = vecs[i].din; spRAZERO = vecs[i].razero;
      spRADDRA = vecs[i].ra; spRADDRB = vecs[i].rb;
      step();
      chk($sformatf("vec%0d_douta", i), 32'(spDOUTA), 32'(vecs[i].expa));
      chk($sformatf("vec%0d_doutb", i), 32'(spDOUTB), 32'(vecs[i].expb));
      chk($sformatf("vec%0d_busy", i), 32'(spBUSY), 0);
    end
    idle();
    chk("perr_idle", 32'(spPERR), 0);

    // Clear with same-cycle write, restart at sweep cycle 6, late writes dropped.
    wr_word(4'd5, 8'h3C);
    spRADDRA = 4'd5; step();
    chk("pre_clear_addr5", 32'(spDOUTA), 32'h3C);
    spCLR = 1; spWR = 1; spCLKEN = 1; spWADDR = 4'd9; spDIN = 8'h42; spRADDRA = 4'd9;
    step();
    spCLR = 0;
    chk("clear_busy", 32'(spBUSY), 1);
    chk("clear_forced_douta", 32'(spDOUTA), 0);
    spWADDR = 4'd0; spDIN = 8'hEE;
    cyc = 1; bad = 0;
    while (spBUSY && cyc < 60) begin
      spCLR = (cyc == 6);
      step();
      if (spBUSY) begin
        cyc++;
        if (spDOUTA !== 8'h00 || spDOUTB !== 8'h00) bad++;
      end
    end
    idle();
    chk("restart_sweep_len", 32'(cyc), 22);
    chk("restart_forced_out", 32'(bad), 0);
    spRADDRA = 4'd5; spRADDRB = 4'd9; step();
    chk("addr5_cleared", 32'(spDOUTA), 0);
    chk("same_cycle_write_overwritten", 32'(spDOUTB), 0);
    spRADDRA = 4'd0; step();
    chk("midsweep_write_dropped", 32'(spDOUTA), 0);

    // Reset at sweep cycle 10 restarts a full sweep.
    wr_word(4'd14, 8'h81);
    spRADDRA = 4'd14; spRADDRB = 4'd14; step();
    chk("pre_reset_addr14", 32'(spDOUTA), 32'h81);
    spCLR = 1; step(); spCLR = 0;
    for (int i = 0; i < 10; i++) step();
    rst = 1; #1;
    chk("midsweep_reset_busy", 32'(spBUSY), 1);
    chk("midsweep_reset_dout", 32'(spDOUTA), 0);
    step();
    rst = 0;
    cyc = 0; bad = 0;
    while (spBUSY && cyc < 40) begin
      if (spDOUTA !== 8'h00 || spDOUTB !== 8'h00) bad++;
      step(); cyc++;
    end
    chk("reset_restart_sweep_len", 32'(cyc), 16);
    chk("reset_restart_forced_out", 32'(bad), 0);
    spRADDRA = 4'd14; step();
    chk("addr14_cleared", 32'(spDOUTA), 0);

`ifdef KMCSP_PARITY_EN
    wr_word(4'd2, 8'h33);
    wr_word(4'd4, 8'h0F);
    dut.mem[2][8] = ~dut.mem[2][8];
    spRADDRA = 4'd2; spRADDRB = 4'd0;
    step(); step();
    chk("perr_flipped", 32'(spPERR), 1);
    spRADDRA = 4'd4;
    step(); step();
    chk("perr_good", 32'(spPERR), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
